// File: rtl/miriscv_mdu_pkg.sv
// Shared opcode encoding, FSM state type and opcode-class helpers for the iterative MDU.
package miriscv_mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
  localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [MDU_OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

  // DIV and REM are the signed division ops; DIVU/REMU have bit 0 set.
  function automatic logic is_sdiv(input logic [MDU_OP_W-1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/miriscv_div_iter.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit per step.
// start loads the operands; done is high while the final (XLEN-th) step is being taken.
module miriscv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // Partial remainder stays below the divisor, so the trial never needs more than XLEN+1 bits.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign done      = (cnt_q == CW'(XLEN - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/miriscv_mdu_iter.sv
// Iterative RISC-V M-extension unit: MUL_STEP-bit-per-cycle multiplier inline, restoring divider in miriscv_div_iter.
// Defining MIRISCV_MDU_DIVREM_CACHE_EN adds a one-entry cache of the last completed division.
module miriscv_mdu_iter
  import miriscv_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                req_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  input  logic                kill_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [XLEN-1:0]     result_o
);
  localparam int N  = XLEN / MUL_STEP;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = XLEN + MUL_STEP;

  mdu_state_e          state_q, state_d;
  logic [MDU_OP_W-1:0] op_q;
  logic [XLEN-1:0]     mcand_q, result_q, res_d, fix_res;
  logic [2*XLEN-1:0]   prod_q, prod_fix;
  logic [CW-1:0]       cnt_q;
  logic                neg_q, aneg_q;
  logic                accept, load_res, div_start, div_step, div_done;
  logic                div_op, a_sgn, b_sgn, a_neg, b_neg, fast, cache_hit;
  logic [XLEN-1:0]     a_mag, b_mag, fast_res, cache_res;
  logic [XLEN-1:0]     quo, rem, quo_fix, rem_fix;
  logic [PW-1:0]       pp_sum;

  assign accept = (state_q == IDLE) && req_i && !kill_i;

  always_comb begin
    div_op   = is_div(op_i);
    a_sgn    = op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    b_sgn    = op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    fast     = 1'b0;
    fast_res = '0;
    if (div_op && (b_i == '0)) begin
      fast     = 1'b1;
      fast_res = is_rem(op_i) ? a_i : '1;
    end else if (div_op && cache_hit) begin
      fast     = 1'b1;
      fast_res = cache_res;
    end else if (!div_op && ((a_i == '0) || (b_i == '0))) begin
      fast     = 1'b1;
      fast_res = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy_o    = (state_q != IDLE);
    valid_o   = (state_q == DONE);
    div_start = accept && div_op;
    div_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fast)        state_d = DONE;
          else if (div_op) state_d = DIV;
          else             state_d = MUL;
        end
      end
      MUL:  if (cnt_q == CW'(N - 1)) state_d = FIX;
      DIV: begin
        div_step = 1'b1;
        if (div_done) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
    load_res = (state_d == DONE) && (state_q != DONE);
    res_d    = (state_q == IDLE) ? fast_res : fix_res;
  end

  // Sign correction applied in FIX; undefined opcode space falls through to MUL.
  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = aneg_q ? -rem : rem;
    case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_res = quo_fix;
      MDU_REM, MDU_REMU:               fix_res = rem_fix;
      default:                         fix_res = prod_fix[XLEN-1:0];
    endcase
  end

  // Multiplier lives in prod_q's low half and is shifted out as the product shifts in.
  assign pp_sum = PW'(prod_q[2*XLEN-1:XLEN]) + PW'(mcand_q) * PW'(prod_q[MUL_STEP-1:0]);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      op_q     <= MDU_MUL;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      aneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        mcand_q <= a_mag;
        prod_q  <= {{XLEN{1'b0}}, b_mag};
        neg_q   <= a_neg ^ b_neg;
        aneg_q  <= a_neg;
        cnt_q   <= '0;
      end else if (state_q == MUL) begin
        prod_q <= {pp_sum, prod_q[XLEN-1:MUL_STEP]};
        cnt_q  <= cnt_q + CW'(1);
      end
      if (load_res) result_q <= res_d;
    end
  end

  assign result_o = result_q;

  miriscv_div_iter #(.XLEN(XLEN)) u_div (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef MIRISCV_MDU_DIVREM_CACHE_EN
  logic            c_vld, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_quo, c_rem, a_q, b_q;

  always_comb begin
    cache_hit = c_vld && (a_i == c_a) && (b_i == c_b) && (c_sgn == is_sdiv(op_i));
    cache_res = is_rem(op_i) ? c_rem : c_quo;
  end

  // Both quotient and remainder are kept so a DIV/REM pair costs one division.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      c_vld <= 1'b0;
      c_sgn <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_quo <= '0;
      c_rem <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      if (accept) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (kill_i) begin
        c_vld <= 1'b0;
      end else if ((state_q == FIX) && is_div(op_q)) begin
        c_vld <= 1'b1;
        c_sgn <= is_sdiv(op_q);
        c_a   <= a_q;
        c_b   <= b_q;
        c_quo <= quo_fix;
        c_rem <= rem_fix;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// Random and directed stimulus for miriscv_mdu_iter, checked each cycle against a cycle-schedule reference model.
module tb_miriscv_mdu_iter;
  import miriscv_mdu_pkg::*;

  localparam int XLEN = 32;

  logic        clk_i   = 1'b0;
  logic        arstn_i = 1'b0;
  logic        req_i   = 1'b0;
  logic        kill_i  = 1'b0;
  logic [2:0]  op_i    = 3'd0;
  logic [31:0] a_i     = '0;
  logic [31:0] b_i     = '0;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_pass   = 0;

  miriscv_mdu_iter #(.XLEN(XLEN), .MUL_STEP(4)) dut (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .req_i    (req_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef MIRISCV_MDU_DIVREM_CACHE_EN
  localparam int CACHE_LAT = 1;
`else
  localparam int CACHE_LAT = XLEN + 2;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference results straight from the M-extension arithmetic definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      MDU_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      MDU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; p = q; return p[31:0]; end
      MDU_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      MDU_REM:    begin if (b == 0) return a; q = sa % sb; p = q; return p[31:0]; end
      MDU_REMU:   begin if (b == 0) return a; return a % b; end
      default:    begin p = sa * sb; return p[31:0]; end
    endcase
  endfunction

  // Model state: cycle index within the current op (0 = idle), its total latency, held result.
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0, m_pend = '0, m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  logic        mc_vld = 1'b0, mc_sgn = 1'b0;
  logic [31:0] mc_a = '0, mc_b = '0;

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 1;
      if (mc_vld && a == mc_a && b == mc_b && mc_sgn == ~op[0]) return CACHE_LAT;
      return XLEN + 2;
    end
    if (a == 0 || b == 0) return 1;
    return XLEN / 4 + 2;
  endfunction

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_cyc = 0; m_res = '0; mc_vld = 1'b0;
    end else if (kill_i) begin
      m_cyc = 0; mc_vld = 1'b0;
    end else if (m_cyc == 0) begin
      if (req_i) begin
        m_op = op_i; m_a = a_i; m_b = b_i;
        m_pend = ref_res(op_i, a_i, b_i);
        m_lat  = ref_lat(op_i, a_i, b_i);
        m_cyc  = 1;
        if (m_lat == 1) m_res = m_pend;
      end
    end else if (m_cyc == m_lat) begin
      m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc == m_lat) begin
        m_res = m_pend;
        if (m_op[2]) begin
          mc_vld = 1'b1; mc_a = m_a; mc_b = m_b; mc_sgn = ~m_op[0];
        end
      end
    end
  end

  always @(negedge clk_i) begin
    check("busy", busy_o, m_cyc != 0);
    check("valid", valid_o, (m_cyc != 0) && (m_cyc == m_lat));
    check("result", result_o, m_res);
  end

  task automatic wait_valid(input string name, input logic [31:0] er, input int ec);
    int vc;
    vc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk_i);
      if (valid_o) begin vc = c; break; end
    end
    check({name, "_cycle"}, vc, ec);
    check({name, "_res"}, result_o, er);
  endtask

  task automatic run_dir(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int ec);
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_valid(name, er, ec);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 9));
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] pa [4];
  logic [31:0] pb [4];
  int          nv;
  int          k;

  initial begin
    check("pin_mul",    ref_res(MDU_MUL,    32'd7,          32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin_mulhu",  ref_res(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulhsu", ref_res(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2),         32'hFFFF_FFFF);
    check("pin_divovf", ref_res(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_div",    ref_res(MDU_DIV,    -32'sd100,      32'd7),         32'hFFFF_FFF2);
    check("pin_rem",    ref_res(MDU_REM,    -32'sd100,      32'd7),         32'hFFFF_FFFE);

    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    @(posedge clk_i); #1;
    arstn_i = 1'b1;

    run_dir("mul",      MDU_MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 10);
    run_dir("mulhu",    MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10);
    run_dir("div_ovf",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run_dir("rem_ovf",  MDU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         CACHE_LAT);
    run_dir("divu_z",   MDU_DIVU,  32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_dir("remu_z",   MDU_REMU,  32'd100,       32'd0,         32'd100,       1);
    run_dir("mulh_z",   MDU_MULH,  32'd0,         32'd5,         32'd0,         1);
    run_dir("div_100",  MDU_DIV,   32'd100,       32'd7,         32'd14,        34);
    run_dir("rem_100",  MDU_REM,   32'd100,       32'd7,         32'd2,         CACHE_LAT);

    // Kill a division in cycle 10, then issue a new op in cycle 11.
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = MDU_DIV; a_i = -32'sd100; b_i = 32'd7;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    req_i = 1'b1; op_i = MDU_MULHU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check("kill_busy", busy_o, 0);
    check("kill_valid", valid_o, 0);
    check("kill_result", result_o, 32'd2);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    wait_valid("after_kill", 32'hFFFF_FFFE, 10);

    // Reset in cycle 5 of a division.
    @(posedge clk_i); #1;
    req_i = 1'b1; op_i = MDU_DIV; a_i = 32'd1000; b_i = 32'd3;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 arstn_i = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_result", result_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    arstn_i = 1'b1;
    nv = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (valid_o) nv++;
    end
    check("arst_novalid", nv, 0);

    for (int i = 0; i < 4; i++) begin
      pa[i] = pick();
      pb[i] = pick();
    end
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #1;
      if (i == 1500) arstn_i = 1'b0;
      if (i == 1503) arstn_i = 1'b1;
      req_i  = ($urandom_range(0, 1) == 1);
      kill_i = ($urandom_range(0, 63) == 0);
      op_i   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        k   = $urandom_range(0, 3);
        a_i = pa[k];
        b_i = pb[k];
      end else begin
        a_i = pick();
        b_i = pick();
      end
    end
    @(posedge clk_i); #1;
    req_i = 1'b0; kill_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
